// File: rtl/mac_pkg.sv
// Shared MAC package: default dimensions plus the controller and
// result-reader state types.
package mac_pkg;

    localparam int MAC_N     = 4;
    localparam int MAC_ACC_W = 20;

    typedef enum logic [1:0] {
        CTRL_IDLE,
        CTRL_LOAD,
        CTRL_RUN,
        CTRL_DONE
    } ctrl_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_STREAM
    } rd_state_t;

endpackage

// File: rtl/mac_result_reader.sv
// Result reader: snapshots the MAC accumulator array on a rising
// out_valid and streams it row-major over a valid/ready port.
module mac_result_reader
    import mac_pkg::*;
#(
    parameter int N     = MAC_N,
    parameter int ACC_W = MAC_ACC_W
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   out_valid,
    input  logic [N*N*ACC_W-1:0]   acc_flat,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ACC_W-1:0]       res_data,
    output logic [$clog2(N)-1:0]   res_row,
    output logic [$clog2(N)-1:0]   res_col,
    output logic                   res_last,
    output logic                   busy,
    output logic                   overrun,
    input  logic                   clr_err
);

    localparam int NE    = N * N;
    localparam int IDX_W = $clog2(NE);
    localparam int RC_W  = $clog2(N);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NE - 1);
    localparam logic [IDX_W-1:0] N_IDX    = IDX_W'(N);

    rd_state_t        state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             ov_q;
    logic             armed_q;
    logic             ovr_d;
    logic             load;
    logic             capture;
    logic             hs;
    logic             final_hs;
    logic [ACC_W-1:0] snap [NE];

    // armed_q blocks a level that is already high at reset release
    // from looking like a rising edge.
    assign capture  = out_valid & ~ov_q & armed_q;
    assign hs       = res_valid & res_ready;
    assign final_hs = hs & res_last;

    // Edge detector for out_valid.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ov_q    <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            ov_q <= out_valid;
            if (!out_valid) begin
                armed_q <= 1'b1;
            end
        end
    end

    // State, index and sticky error registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RD_IDLE;
            idx_q   <= '0;
            overrun <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            overrun <= ovr_d;
        end
    end

    // Snapshot buffer; outputs are gated while idle so it needs no reset.
    always_ff @(posedge clock) begin
        if (load) begin
            for (int k = 0; k < NE; k++) begin
                snap[k] <= acc_flat[k*ACC_W +: ACC_W];
            end
        end
    end

    // Stream outputs decoded from state and index.
    always_comb begin
        busy      = (state_q == RD_STREAM);
        res_valid = busy;
        res_last  = busy && (idx_q == LAST_IDX);
        res_data  = busy ? snap[idx_q] : '0;
        res_row   = RC_W'(idx_q / N_IDX);
        res_col   = RC_W'(idx_q % N_IDX);
    end

    // Next-state, index advance, snapshot load and overrun logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        ovr_d   = overrun;
        if (clr_err) begin
            ovr_d = 1'b0;
        end
        unique case (state_q)
            RD_IDLE: begin
                if (capture) begin
                    state_d = RD_STREAM;
                    idx_d   = '0;
                    load    = 1'b1;
                end
            end
            RD_STREAM: begin
                if (final_hs) begin
                    idx_d = '0;
                    if (capture) begin
                        load = 1'b1;
                    end else begin
                        state_d = RD_IDLE;
                    end
                end else begin
                    if (hs) begin
                        idx_d = idx_q + 1'b1;
                    end
                    if (capture) begin
                        ovr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = RD_IDLE;
                idx_d   = '0;
            end
        endcase
    end

endmodule

// File: doc/mac_result_reader.md
MAC_RESULT_READER -- requirements
Module: mac_result_reader

Interface
REQ-001 SHALL have parameter N, default 4, meaning matrix dimension (N x N results).
REQ-002 SHALL have parameter ACC_W, default 20, meaning accumulator element width in bits.
REQ-003 SHALL have port clock  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port out_valid  input  1  level from the MAC controller, high while results are valid.
REQ-006 SHALL have port acc_flat  input  N*N*ACC_W  accumulator array; element (r,c) at bits [(r*N+c)*ACC_W +: ACC_W].
REQ-007 SHALL have port res_valid  output  1  stream element valid.
REQ-008 SHALL have port res_ready  input  1  downstream accepts the element.
REQ-009 SHALL have port res_data  output  ACC_W  current element.
REQ-010 SHALL have port res_row / res_col  output  $clog2(N) each  indices of the current element.
REQ-011 SHALL have port res_last  output  1  high with element (N-1,N-1).
REQ-012 SHALL have port busy  output  1  snapshot held or being streamed.
REQ-013 SHALL have port overrun  output  1  sticky: new result set arrived while busy.
REQ-014 SHALL have port clr_err  input  1  synchronous clear of overrun.

Function
REQ-015 SHALL register out_valid and detect its rising edge (out_valid high, registered copy low) as the capture event.
REQ-016 SHALL implement states IDLE and STREAM; IDLE->STREAM on capture event, STREAM->IDLE on handshake (res_valid && res_ready) with res_last high.
REQ-017 SHALL, on a capture event, copy all of acc_flat into an internal snapshot buffer at that clock edge and reset the element index to 0.
REQ-018 SHALL assert res_valid in the cycle after the capture edge (1-cycle latency) and keep it high for every STREAM cycle.
REQ-019 SHALL stream in row-major order, index 0..N*N-1, res_row = index / N, res_col = index mod N, res_data from the snapshot, never from live acc_flat.
REQ-020 SHALL advance the index only on a handshake; res_data, res_row, res_col and res_last SHALL remain stable while res_valid && !res_ready.
REQ-021 SHALL treat element data as raw bits (no sign extension, no arithmetic); the index counter SHALL be $clog2(N*N) bits and SHALL not wrap within a set.
REQ-022 SHALL, on a capture event during STREAM that does not coincide with the final handshake, set overrun, ignore the new data and leave the current stream undisturbed.
REQ-023 SHALL, when a capture event coincides with the final handshake, accept the new set (snapshot, index 0, stay in STREAM) without setting overrun.
REQ-024 SHALL hold out_valid continuously high as a single event (no re-capture until out_valid falls and rises again).
REQ-025 SHALL drive busy = (state == STREAM).
REQ-026 SHALL clear overrun on clr_err; if clr_err and a new overrun occur in the same cycle, overrun SHALL end set.

Reset
REQ-027 SHALL, while reset_n is low, force state IDLE, index 0, registered out_valid 0, res_valid 0, res_last 0, busy 0, overrun 0, res_row/res_col 0, res_data 0.
REQ-028 SHALL abort any stream on reset mid-operation; no element is emitted after reset release until a fresh capture event.
REQ-029 SHALL, if out_valid is already high at reset release, not treat it as a rising edge.

Structure
REQ-030 SHALL take N, ACC_W defaults and the reader state enum from shared package mac_pkg, alongside the controller's state type.
REQ-031 SHALL be a single module with no sub-modules; edge detect, snapshot register and index counter inline.

Verification
REQ-032 Basic: acc_flat element k = k+100, out_valid rises, res_ready=1 -> 16 elements 100..115 on consecutive cycles, first one cycle after capture, res_last with 115, busy low after.
REQ-033 Backpressure: res_ready toggles 1,0,0,1 repeating -> same 16 values in order, outputs stable during stalls, no drops or duplicates.
REQ-034 Snapshot: acc_flat changed to all 0xFFFFF mid-stream -> remaining elements still show captured values.
REQ-035 Overrun: second out_valid rise at element 5 -> overrun=1, stream continues 5..15 unchanged; clr_err pulse -> overrun=0.
REQ-036 Back-to-back: new rise coinciding with final handshake -> second set streams immediately, overrun stays 0.
REQ-037 Reset: reset_n low at element 7 -> res_valid 0 same cycle; out_valid held high across release -> no stream until it falls and rises.
